trace_stream_serializer: RTL and testbench

//  Downstream consumer of the core's 128-bit commit-trace AXI-stream (TRACE_t*).

---
 rtl/trace_stream_serializer.sv | 145 ++++++++++++++
 tb/tb_trace_stream_serializer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trace_stream_serializer.sv
// trace_stream_serializer
//   Takes 128-bit commit-trace beats from the core and queues them in a small
//   FIFO. It then sends each beat out as four 32-bit words on the host stream,
//   PC word first. When the host is slow, s_tready drops and the trace source
//   stalls, so no beat is lost.
//
// Ports
//   clk, rst           clock; synchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast   128-bit input stream
//   m_tdata/m_tvalid/m_tready/m_tlast   32-bit output stream
//   beats_in           accepted input beats (wraps)
//   words_out          emitted output words (wraps)
//   busy               FIFO non-empty or a beat is being serialized
module trace_stream_serializer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  output logic [31:0]      m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [CNT_W-1:0] beats_in,
  output logic [CNT_W-1:0] words_out,
  output logic             busy
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [128:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [127:0]  hold_data;
  logic          hold_last;
  logic [1:0]    idx;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          out_hs;

  // The extra pointer MSB tells a full FIFO apart from an empty one.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // Full comes from the registered pointers only. A same-cycle pop does not
  // let a new beat in, so there is no combinational path from m_tready to
  // s_tready.
  assign s_tready = !full;
  assign push     = s_tvalid && !full;

  assign m_tvalid = (state == SEND);
  assign out_hs   = m_tvalid && m_tready;
  assign m_tdata  = m_tvalid ? hold_data[{idx, 5'b0} +: 32] : '0;
  assign m_tlast  = m_tvalid && hold_last && (idx == 2'd3);
  assign busy     = !empty || m_tvalid;

  // A beat is loaded when the serializer is idle. It is also loaded right
  // after the last word of the current beat, so there is no bubble.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE: pop = !empty;
      SEND: pop = out_hs && (idx == 2'd3) && !empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {s_tlast, s_tdata};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      if (pop) begin
        {hold_last, hold_data} <= mem[rd_ptr[AW-1:0]];
      end
      case (state)
        IDLE: begin
          if (pop) begin
            idx   <= '0;
            state <= SEND;
          end
        end
        SEND: begin
          if (out_hs) begin
            if (idx != 2'd3) begin
              idx <= idx + 2'd1;
            end else if (pop) begin
              idx <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_in  <= '0;
      words_out <= '0;
    end else begin
      if (push) begin
        beats_in <= beats_in + CNT_W'(1);
      end
      if (out_hs) begin
        words_out <= words_out + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_trace_stream_serializer.sv
// Testbench for trace_stream_serializer. The stimulus queues the expected
// output words. A negedge monitor pops them and compares on each output
// handshake. While the output is stalled, the monitor also checks that
// m_tdata and m_tvalid stay stable.
module tb_trace_stream_serializer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [127:0]     s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tready;
  logic             s_tlast = 1'b0;
  logic [31:0]      m_tdata;
  logic             m_tvalid;
  logic             m_tready = 1'b0;
  logic             m_tlast;
  logic [CNT_W-1:0] beats_in;
  logic [CNT_W-1:0] words_out;
  logic             busy;

  int unsigned tests = 0;
  int unsigned fails = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_exp;
  logic        stall_pend = 1'b0;
  logic [31:0] stall_data = '0;
  int unsigned run_len = 0;
  int unsigned max_run = 0;
  logic        rnd_done;

  trace_stream_serializer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_tdata  (s_tdata),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tlast  (s_tlast),
    .m_tdata  (m_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .beats_in (beats_in),
    .words_out(words_out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_beat(input logic [31:0] pc, input logic [31:0] wd,
                                           input logic [4:0] rd, input logic we);
    return {58'd0, we, rd, wd, pc};
  endfunction

  function automatic void queue_beat(input logic [127:0] d, input logic l);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({(l && i == 3), d[32*i +: 32]});
    end
  endfunction

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
      run_len    = 0;
    end else begin
      if (stall_pend) begin
        check("stall_valid", 64'(m_tvalid), 64'd1);
        check("stall_data", 64'(m_tdata), 64'(stall_data));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_word: got 0x%0h, expected no word", m_tdata);
        end else begin
          mon_exp = exp_q.pop_front();
          check("word_data", 64'(m_tdata), 64'(mon_exp[31:0]));
          check("word_last", 64'(m_tlast), 64'(mon_exp[32]));
        end
      end
      stall_pend = m_tvalid && !m_tready;
      stall_data = m_tdata;
      if (m_tvalid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  end

  task automatic apply_reset();
    rst      = 1'b1;
    s_tvalid = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drives one beat and waits (bounded) until it is accepted. Returns at
  // posedge+1 with s_tvalid low.
  task automatic send_beat(input logic [127:0] d, input logic l, input logic do_queue);
    int unsigned n = 0;
    s_tdata  = d;
    s_tlast  = l;
    s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got s_tready=0, expected acceptance within 500 cycles");
      s_tvalid = 1'b0;
    end else begin
      @(posedge clk);
      if (do_queue) queue_beat(d, l);
      #1;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] b;
    int unsigned  k;
    logic         acc;

    // ---- Reset state
    apply_reset();
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_m_tlast", 64'(m_tlast), 64'd0);
    check("rst_m_tdata", 64'(m_tdata), 64'd0);
    check("rst_beats_in", 64'(beats_in), 64'd0);
    check("rst_words_out", 64'(words_out), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    // ---- 1: single beat, latency and word order
    m_tready = 1'b1;
    b = mk_beat(32'h0000_0100, 32'hDEAD_BEEF, 5'h0A, 1'b1);
    exp_q.push_back({1'b0, 32'h0000_0100});
    exp_q.push_back({1'b0, 32'hDEAD_BEEF});
    exp_q.push_back({1'b0, 32'h0000_002A});
    exp_q.push_back({1'b1, 32'h0000_0000});
    send_beat(b, 1'b1, 1'b0);
    @(negedge clk);
    check("t1_lat_valid_n", 64'(m_tvalid), 64'd0);
    check("t1_lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("t1_lat_valid_n1", 64'(m_tvalid), 64'd1);
    check("t1_word0", 64'(m_tdata), 64'h100);
    wait_drain("t1");
    check("t1_beats_in", 64'(beats_in), 64'd1);
    check("t1_words_out", 64'(words_out), 64'd4);

    // ---- 2: fill with output stalled -> DEPTH+1 accepted
    apply_reset();
    m_tready = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      b = mk_beat(32'h2000 + 32'(4 * k), 32'hC0DE_0000 + 32'(k), 5'(k), 1'b1);
      s_tdata  = b;
      s_tlast  = 1'b0;
      s_tvalid = 1'b1;
      @(negedge clk);
      acc = s_tready;
      @(posedge clk);
      if (acc) begin
        queue_beat(b, 1'b0);
        k++;
      end
      #1;
    end
    check("t2_accepted", 64'(k), 64'(DEPTH + 1));
    check("t2_s_tready", 64'(s_tready), 64'd0);
    check("t2_beats_in", 64'(beats_in), 64'(DEPTH + 1));
    check("t2_held_word0", 64'(m_tdata), 64'h2000);
    check("t2_valid", 64'(m_tvalid), 64'd1);

    // ---- 6: push at full while the serializer pops -> push refused
    b = mk_beat(32'h6666_0000, 32'h6666_1111, 5'h1F, 1'b0);
    s_tdata  = b;
    s_tlast  = 1'b1;
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t6_full_hold", 64'(s_tready), 64'd0);
    end
    @(negedge clk);
    check("t6_after_pop_ready", 64'(s_tready), 64'd1);
    check("t6_beats_unchanged", 64'(beats_in), 64'(DEPTH + 1));
    @(posedge clk);
    queue_beat(b, 1'b1);
    #1;
    s_tvalid = 1'b0;
    wait_drain("t6");
    check("t6_beats_in", 64'(beats_in), 64'(DEPTH + 2));
    check("t6_words_out", 64'(words_out), 64'(4 * (DEPTH + 2)));

    // ---- 3: 8 back-to-back beats, no bubble
    apply_reset();
    m_tready = 1'b1;
    max_run  = 0;
    for (int i = 0; i < 8; i++) begin
      b = mk_beat(32'h3000 + 32'(i), 32'h3300_0000 + 32'(i * 7), 5'(i + 3), i[0]);
      send_beat(b, (i == 7), 1'b1);
    end
    wait_drain("t3");
    check("t3_no_bubble_run", 64'(max_run), 64'd32);
    check("t3_words_out", 64'(words_out), 64'd32);
    check("t3_beats_in", 64'(beats_in), 64'd8);

    // ---- 4: 100 beats with random host backpressure
    apply_reset();
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 100; i++) begin
          b = mk_beat(32'h4000_0000 + 32'(i * 4), 32'hA5A5_0000 ^ 32'(i * 263),
                      5'(i * 3), i[1]);
          send_beat(b, (i == 99), 1'b1);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          m_tready = 1'($urandom_range(0, 1));
        end
      end
    join
    m_tready = 1'b1;
    wait_drain("t4");
    check("t4_beats_in", 64'(beats_in), 64'd100);
    check("t4_words_out", 64'(words_out), 64'd400);

    // ---- 5: reset mid-beat with a non-empty FIFO
    apply_reset();
    m_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      b = mk_beat(32'h5000 + 32'(i), 32'h5500_0000 + 32'(i), 5'(i), 1'b1);
      send_beat(b, 1'b1, 1'b1);
    end
    m_tready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    check("t5_word2_pending", 64'(m_tdata), 64'h20);
    check("t5_pre_valid", 64'(m_tvalid), 64'd1);
    check("t5_pre_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("t5_m_tvalid", 64'(m_tvalid), 64'd0);
    check("t5_s_tready", 64'(s_tready), 64'd1);
    check("t5_beats_in", 64'(beats_in), 64'd0);
    check("t5_words_out", 64'(words_out), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_m_tlast", 64'(m_tlast), 64'd0);
    rst = 1'b0;
    m_tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_resume", 64'(m_tvalid), 64'd0);
    check("t5_words_stay0", 64'(words_out), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
